// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bundle of the fetch stage's redirect input, instruction
// memory port and decode-side valid/ready output.
//   master : the fetch stage (drives imem request and decode output)
//   slave  : the surroundings (next-PC mux, instruction memory, decode)
// Signals:
//   pc_next_i / redirect_i    redirect target and strobe
//   imem_req_o / imem_addr_o  memory read request and address
//   imem_rdata_i              read data, one cycle after the request
//   out_valid_o / out_ready_i decode handshake
//   out_pc_o / out_instr_o    head {pc, instr} pair
interface fetch_stage_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] pc_next_i;
    logic             redirect_i;
    logic             imem_req_o;
    logic [WIDTH-1:0] imem_addr_o;
    logic [WIDTH-1:0] imem_rdata_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] out_pc_o;
    logic [WIDTH-1:0] out_instr_o;

    modport master (
        input  pc_next_i, redirect_i, imem_rdata_i, out_ready_i,
        output imem_req_o, imem_addr_o, out_valid_o, out_pc_o, out_instr_o
    );

    modport slave (
        output pc_next_i, redirect_i, imem_rdata_i, out_ready_i,
        input  imem_req_o, imem_addr_o, out_valid_o, out_pc_o, out_instr_o
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage owning the program counter.
// Issues sequential reads to a 1-cycle-latency instruction memory, buffers
// returned {pc, instr} pairs in a DEPTH-entry FIFO and presents the head to
// decode over valid/ready. A redirect loads a new PC and flushes the buffer
// and any response in flight.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fetch_stage_if.master (redirect, imem port, decode handshake)
module fetch_stage #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int STEP = WIDTH / 8;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
    } entry_t;

    entry_t           fifo [DEPTH];
    logic [PW-1:0]    head, tail;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] pc, inflight_pc;
    logic             inflight, drop;

    logic             pop, push, req;
    logic [CW:0]      occ;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pop  = (count != '0) && bus.out_ready_i;
    // A response arriving in a redirect cycle belongs to the old path.
    assign push = inflight && !drop && !bus.redirect_i;
    // Occupancy after this edge if a request were not issued; the slot for
    // a new request must exist before it goes out, so the FIFO never overflows.
    assign occ  = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    // rst_n gates the request so the port is quiet while reset is held.
    assign req  = rst_n && !bus.redirect_i && (occ < (CW+1)'(DEPTH));

    assign bus.imem_req_o  = req;
    assign bus.imem_addr_o = pc;
    assign bus.out_valid_o = (count != '0);
    assign bus.out_pc_o    = (count != '0) ? fifo[head].pc    : '0;
    assign bus.out_instr_o = (count != '0) ? fifo[head].instr : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            drop        <= 1'b0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
        end else if (bus.redirect_i) begin
            pc       <= bus.pc_next_i;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            inflight <= 1'b0;
            // Marks the cancelled response slot; no request issues in the
            // redirect cycle, so nothing new is in flight behind it.
            drop     <= inflight;
        end else begin
            drop     <= 1'b0;
            inflight <= req;
            if (req) begin
                pc          <= pc + WIDTH'(STEP);
                inflight_pc <= pc;
            end
            if (push) tail <= ptr_next(tail);
            if (pop)  head <= ptr_next(head);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    // Storage needs no reset: nothing is visible while count is zero.
    always_ff @(posedge clk) begin
        if (push) fifo[tail] <= '{pc: inflight_pc, instr: bus.imem_rdata_i};
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage owning the program counter.
- Consumes the next-PC value produced by the branch-target mux2 (`pc_next_i`) when `redirect_i` is asserted; otherwise it advances sequentially.
- Issues requests to a 1-cycle-latency synchronous instruction memory.
- Buffers returned {pc, instr} pairs in a small FIFO and hands them to decode over a valid/ready handshake.

Parameters:
- WIDTH, 32, address and instruction width in bits; PC step is WIDTH/8.
- RESET_PC, 0, PC value loaded on reset.
- DEPTH, 2, output buffer entries (at least 2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- pc_next_i  input  WIDTH  redirect target from the next-PC mux2.
- redirect_i  input  1  taken branch/jump; load `pc_next_i` and flush.
- imem_req_o  output  1  instruction memory read request.
- imem_addr_o  output  WIDTH  request address; equals the current PC.
- imem_rdata_i  input  WIDTH  read data, valid exactly 1 cycle after an accepted request.
- out_valid_o  output  1  buffer head valid.
- out_ready_i  input  1  decode accepts head.
- out_pc_o  output  WIDTH  PC of head instruction.
- out_instr_o  output  WIDTH  head instruction.

Behaviour:
- Reset (`rst_n`=0, asynchronous):
  - pc=RESET_PC, count=0, inflight=0, drop=0.
  - imem_req_o=0, out_valid_o=0, out_pc_o=0, out_instr_o=0.
  - Outputs hold these values throughout reset.
  - Asserting reset mid-stream discards all buffered and in-flight data immediately.
- State:
  - pc register.
  - FIFO of DEPTH {pc, instr} entries: head/tail pointers wrap modulo DEPTH; count ranges 0..DEPTH.
  - inflight flag (0/1), inflight pc latch, drop flag.
- Pop: pop = out_valid_o && out_ready_i.
- Request rule (combinational):
  - imem_req_o = !redirect_i && (count + inflight - pop) < DEPTH.
  - imem_addr_o = pc always.
- Issue: on an edge with imem_req_o=1:
  - pc <= pc + WIDTH/8, modulo 2^WIDTH; 0xFFFFFFFC wraps to 0x00000000.
  - inflight <= 1; the issued pc is latched for its response.
- Response: in the cycle with inflight=1 and drop=0, {latched pc, imem_rdata_i} is pushed at the next edge.
  - Push and pop in the same cycle are legal at any count, including count=DEPTH.
  - Count is unchanged when both occur.
- Redirect: on an edge with redirect_i=1:
  - pc <= pc_next_i.
  - count <= 0; any pop in that cycle is ignored, and no FIFO write occurs.
  - If a response is in flight, it is discarded (drop <= 1 for exactly that response).
  - imem_req_o is 0 in the redirect cycle.
  - The first request at the new target issues the following cycle.
- Redirect while reset is asserted has no effect.
- Output:
  - out_valid_o = (count != 0); out_pc_o and out_instr_o show the FIFO head.
  - Outputs are 0 when count=0.
  - Head data is stable while out_valid_o && !out_ready_i.
- Latency: request in cycle N → data pushed at the end of N+1 → out_valid_o in N+2.
- Steady state with out_ready_i=1: one instruction per cycle.
- Order: strictly in PC order; no instruction is duplicated or skipped except via redirect.

Test Plan:
1. Reset then stream:
   - Stimulus: rst_n released, out_ready_i=1, memory returns addr^32'hA5A5A5A5.
   - Required: req addresses 0,4,8,…; out_valid_o first high 2 cycles after the first req; out_pc_o 0,4,8 on consecutive cycles.
2. Backpressure:
   - Stimulus: out_ready_i=0 from the start.
   - Required: exactly DEPTH=2 requests (0,4); imem_req_o then low; head holds pc=0 stable.
   - Then out_ready_i=1: drains 0,4, then 8 follows with no gap or duplicate.
3. Redirect with in-flight response:
   - Stimulus: mid-stream with 1 entry buffered and a request in flight, pulse redirect_i with pc_next_i=0x100.
   - Required: imem_req_o=0 in that cycle; buffer empties; the in-flight data never appears; next req addresses 0x100,0x104; next out_pc_o=0x100.
4. PC wrap:
   - Stimulus: redirect to 0xFFFFFFF8.
   - Required: request addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; outputs delivered in that order.
5. Simultaneous push/pop at full:
   - Stimulus: count=2 with out_ready_i toggling 1/0 per cycle.
   - Required: count never exceeds 2; delivered PC sequence is contiguous.
6. Async reset mid-stream:
   - Stimulus: drop rst_n between clock edges.
   - Required: out_valid_o and imem_req_o go 0 immediately.
   - After release, first req addr = RESET_PC; no stale instruction delivered.
